uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart to the team's oversampling UART receiver. Uses the same frame options: 7/8 data bits, none/even/odd parity, 1/2 stop bits.
- Serialises one byte per valid/ready handshake, LSB first, onto line `tx`.
- Bit timing comes from the shared baud-rate generator tick, which runs at OVERSAMPLE ticks per bit.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per transmitted bit; legal values 2..256.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- baud_tick  input  1  one-clk-wide enable pulse from the baud generator
- tx_data  input  8  byte to send; bit 7 ignored when d_num=0
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a byte this cycle
- d_num  input  1  0 = 7 data bits, 1 = 8 data bits
- par  input  2  00 none, 01 even, 10 odd, 11 none
- s_num  input  1  0 = 1 stop bit, 1 = 2 stop bits
- tx  output  1  serial line, idle high
- busy  output  1  a frame is in progress
- tx_done  output  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset values: tx=1, busy=0, tx_done=0, tx_ready=1, FSM in IDLE, counters 0. Reset has priority over all other inputs. Reset mid-frame aborts the frame; tx is 1 on the next cycle.
- Handshake: a byte is accepted on the clk edge where tx_valid && tx_ready. On acceptance, tx_data, d_num, par and s_num are latched. Later changes to these inputs do not affect the frame in flight.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On acceptance -> START, and tx=0 from the next cycle (1-cycle latency).
  - Each bit holds for exactly OVERSAMPLE baud_tick pulses; the tick counter advances only on baud_tick.
  - START -> DATA after OVERSAMPLE ticks.
  - DATA: sends data bit index 0..N-1, where N=7 (d_num=0) or 8 (d_num=1).
  - After the last data bit: -> PARITY if par is 01 or 10, otherwise -> STOP.
  - PARITY: even mode sends the XOR of the N data bits. Odd mode sends the inverse of that XOR.
  - STOP: tx=1 for 1 or 2 bit periods per s_num.
  - At the end of the last stop bit: tx_done=1 for one clk, busy=0, -> IDLE.
- busy=1 from the cycle after acceptance through the final STOP clk.
- tx_ready = (state==IDLE) when the FIFO option is disabled. A new byte can be accepted in the same cycle tx_done pulses, so frames run back-to-back with no idle gap.
- Frame length in bit periods = 1 + N + (parity ? 1 : 0) + (s_num ? 2 : 1); minimum 9, maximum 12.
- The tick counter wraps to 0 at the end of each bit period. The bit index counter saturates at N-1 and clears on leaving DATA.
- baud_tick asserted in the acceptance cycle is not counted toward the start bit.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined: a 4-entry input FIFO, 12 bits wide, holds data and the latched config.
  - tx_ready = !fifo_full. Bytes can be accepted while busy.
  - The FSM pops the next entry in IDLE and begins START on the cycle after the pop.
  - Reset empties the FIFO.
- Undefined: no FIFO; the handshake is exactly as described under Behaviour.

Test Plan:
- Defaults, d_num=1, par=01, s_num=0, send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,0(parity),1. Each bit is 16 ticks; 176 ticks total; one tx_done pulse.
- d_num=0, par=10, s_num=1, send 0x41 -> 0,1,0,0,0,0,0,1,1(parity),1,1. 11 bits total; tx_data[7] has no effect.
- par=11, send 0xA3 with 1 stop bit -> no parity bit; 10-bit frame 0,1,1,0,0,0,1,0,1,1.
- tx_valid held high with two bytes 0x12 then 0x34 -> tx_ready low while busy. 0x34 is accepted in the tx_done cycle, and its start bit follows immediately with no idle gap.
- Assert reset for one cycle during DATA bit 3 -> next cycle tx=1, busy=0, tx_ready=1, tx_done stays 0. A subsequent 0x55 frame is correct.
- UART_TX_FIFO_EN defined, push 5 bytes back-to-back while idle -> 1st byte is taken by the FSM and the next 4 fill the FIFO, so all 5 are accepted. A 6th is refused, with tx_ready=0 until the first frame's FIFO pop. All bytes are transmitted in order.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte handshake plus per-frame configuration for uart_tx_frame.
// The master drives a byte and its frame options; the slave answers with tx_ready.
interface uart_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       d_num;
  logic [1:0] par;
  logic       s_num;

  modport master (
    output tx_data,
    output tx_valid,
    output d_num,
    output par,
    output s_num,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  d_num,
    input  par,
    input  s_num,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, LSB first, 7/8 data bits, none/even/odd
// parity, 1/2 stop bits. Every bit lasts OVERSAMPLE baud_tick pulses.
// Optional build macro UART_TX_FIFO_EN adds a 4-entry input FIFO (data + config),
// so bytes can be accepted while a frame is in flight.
module uart_tx_frame #(
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            baud_tick,
  uart_tx_frame_if.slave  tx_if,
  output logic            tx,
  output logic            busy,
  output logic            tx_done
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Parity of the active data bits; odd mode inverts the even result.
  function automatic logic calc_parity(input logic [7:0] d, input logic dn, input logic [1:0] p);
    logic [7:0] mask;
    mask = dn ? 8'hFF : 8'h7F;
    return (^(d & mask)) ^ (p == 2'b10);
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    data_q, data_d;
  logic          dnum_q, dnum_d;
  logic [1:0]    par_q, par_d;
  logic          snum_q, snum_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          load_s;        // a frame (data + config) is taken this cycle
  logic [11:0]   load_word_s;   // {s_num, par, d_num, data}
  logic          bit_end_s;
  logic [2:0]    n_last_s;
  logic          par_en_s;

  assign tx             = tx_q;
  assign busy           = busy_q;
  assign tx_done        = done_q;
  assign tx_if.tx_ready = ready_q;

`ifdef UART_TX_FIFO_EN
  logic [11:0] fifo_mem_q [0:3];
  logic [1:0]  wr_q, rd_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        push_s;

  assign push_s      = tx_if.tx_valid && ready_q;
  assign load_s      = (state_q == S_IDLE) && (cnt_q != 3'd0);
  assign load_word_s = fifo_mem_q[rd_q];

  // FIFO occupancy after this cycle's push/pop; ready reflects free space.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, load_s})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != 3'd4);
  end

  // FIFO storage and pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 12'd0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push_s) begin
        fifo_mem_q[wr_q] <= {tx_if.s_num, tx_if.par, tx_if.d_num, tx_if.tx_data};
        wr_q             <= wr_q + 2'd1;
      end
      if (load_s) begin
        rd_q <= rd_q + 2'd1;
      end
    end
  end
`else
  assign load_s      = tx_if.tx_valid && ready_q;
  assign load_word_s = {tx_if.s_num, tx_if.par, tx_if.d_num, tx_if.tx_data};

  // Without a FIFO the block only accepts a byte while idle.
  always_comb begin
    ready_d = (state_d == S_IDLE);
  end
`endif

  assign bit_end_s = baud_tick && (tick_q == TICK_LAST);
  assign n_last_s  = dnum_q ? 3'd7 : 3'd6;
  assign par_en_s  = (par_q == 2'b01) || (par_q == 2'b10);

  // Next-state logic: bit timing, bit/stop counters and frame sequencing.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    dnum_d  = dnum_q;
    par_d   = par_q;
    snum_d  = snum_q;
    done_d  = 1'b0;

    // The tick counter only runs inside a frame, so a tick in the
    // acceptance cycle never counts toward the start bit.
    if (state_q != S_IDLE && baud_tick) begin
      tick_d = bit_end_s ? TW'(0) : tick_q + TW'(1);
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        tick_d = TW'(0);
        bit_d  = 3'd0;
        stop_d = 1'b0;
        if (load_s) begin
          data_d  = load_word_s[7:0];
          dnum_d  = load_word_s[8];
          par_d   = load_word_s[10:9];
          snum_d  = load_word_s[11];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          if (bit_q == n_last_s) begin
            bit_d   = 3'd0;
            stop_d  = 1'b0;
            state_d = par_en_s ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (stop_q == snum_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line and status values for the upcoming cycle, derived from the next state.
  always_comb begin
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_d];
      S_PARITY: tx_d = calc_parity(data_d, dnum_d, par_d);
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= TW'(0);
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      data_q  <= 8'd0;
      dnum_q  <= 1'b0;
      par_q   <= 2'b00;
      snum_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      dnum_q  <= dnum_d;
      par_q   <= par_d;
      snum_q  <= snum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

endmodule
